// File: rtl/config_tile_writer.sv
// config_tile_writer: write-side engine for the tile-index screen buffer.
// Turns PUT / HRUN / RECT / CLEAR commands into one buffer write per cycle,
// with address = row*COLS + col. Row bases advance by adding COLS, so the
// write loop contains no multiplier.
//
// Handshake: a command is taken on a rising edge where cmd_valid_in and
// cmd_ready_out are both high. cmd_ready_out is high whenever the engine is
// not writing, including the done_out cycle. Command inputs are don't-care
// while cmd_ready_out is low.
module config_tile_writer #(
   parameter int COLS       = 40,
   parameter int ROWS       = 23,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  cmd_valid_in,
   output logic                  cmd_ready_out,
   input  logic [1:0]            cmd_in,
   input  logic [5:0]            col_in,
   input  logic [4:0]            row_in,
   input  logic [5:0]            width_in,
   input  logic [4:0]            height_in,
   input  logic [7:0]            tile_in,
   output logic [ADDR_WIDTH-1:0] buf_write_addr_out,
   output logic [7:0]            buf_write_data_out,
   output logic                  buf_write_en_out,
   output logic                  done_out,
   output logic                  err_out,
   output logic [1:0]            state_dbg_out
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WRITE  = 2'd1,
      ST_FINISH = 2'd2
   } state_t;

   localparam logic [1:0] CMD_PUT   = 2'd0;
   localparam logic [1:0] CMD_RECT  = 2'd2;
   localparam logic [1:0] CMD_CLEAR = 2'd3;

   localparam logic [6:0]            COLS7  = 7'(COLS);
   localparam logic [5:0]            ROWS6  = 6'(ROWS);
   localparam logic [ADDR_WIDTH-1:0] COLS_A = ADDR_WIDTH'(COLS);

   // Row base r*COLS as a shift-add over the set bits of COLS (constant).
   function automatic logic [ADDR_WIDTH-1:0] row_base_of(input logic [5:0] r);
      logic [ADDR_WIDTH-1:0] acc;
      acc = '0;
      for (int i = 0; i < ADDR_WIDTH; i++) begin
         if (COLS_A[i]) acc = acc + (ADDR_WIDTH'(r) << i);
      end
      return acc;
   endfunction

   state_t                state_q, state_d;
   logic [6:0]            cur_col_q, cur_col_d;
   logic [5:0]            cur_row_q, cur_row_d;
   logic [6:0]            col_start_q, col_start_d;
   logic [6:0]            col_end_q, col_end_d;
   logic [5:0]            row_end_q, row_end_d;
   logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
   logic [ADDR_WIDTH-1:0] addr_d;
   logic [7:0]            data_d;
   logic                  en_d, done_d, err_d, ready_d;

   // Command decode: region bounds as [start, end) in columns and rows.
   logic [6:0]            c0, col_sum, col_clip, s_col, e_col;
   logic [5:0]            r0, row_sum, row_clip, s_row, e_row;
   logic                  reject, empty, col_last, row_last;
   logic [ADDR_WIDTH-1:0] base;

   assign state_dbg_out = state_q;

   // Next-state and next-output logic; every registered output is computed here.
   always_comb begin
      state_d     = state_q;
      cur_col_d   = cur_col_q;
      cur_row_d   = cur_row_q;
      col_start_d = col_start_q;
      col_end_d   = col_end_q;
      row_end_d   = row_end_q;
      row_base_d  = row_base_q;
      addr_d      = buf_write_addr_out;
      data_d      = buf_write_data_out;
      en_d        = 1'b0;
      done_d      = 1'b0;
      err_d       = 1'b0;

      c0       = {1'b0, col_in};
      r0       = {1'b0, row_in};
      col_sum  = c0 + {1'b0, width_in};
      row_sum  = r0 + {1'b0, height_in};
      col_clip = (col_sum > COLS7) ? COLS7 : col_sum;
      row_clip = (row_sum > ROWS6) ? ROWS6 : row_sum;

      if (cmd_in == CMD_CLEAR) begin
         s_col = 7'd0;
         s_row = 6'd0;
         e_col = COLS7;
         e_row = ROWS6;
      end else begin
         s_col = c0;
         s_row = r0;
         e_col = (cmd_in == CMD_PUT)  ? c0 + 7'd1 : col_clip;
         e_row = (cmd_in == CMD_RECT) ? row_clip  : r0 + 6'd1;
      end
      reject = (cmd_in != CMD_CLEAR) && ((c0 >= COLS7) || (r0 >= ROWS6));
      empty  = (e_col == s_col) || (e_row == s_row);
      base   = row_base_of(s_row);

      col_last = (cur_col_q == col_end_q - 7'd1);
      row_last = (cur_row_q == row_end_q - 6'd1);

      case (state_q)
         ST_IDLE, ST_FINISH: begin
            state_d = ST_IDLE;
            if (cmd_valid_in && cmd_ready_out) begin
               if (reject) begin
                  state_d = ST_FINISH;
                  done_d  = 1'b1;
                  err_d   = 1'b1;
               end else if (empty) begin
                  state_d = ST_FINISH;
                  done_d  = 1'b1;
               end else begin
                  state_d     = ST_WRITE;
                  en_d        = 1'b1;
                  addr_d      = base + ADDR_WIDTH'(s_col);
                  data_d      = tile_in;
                  cur_col_d   = s_col;
                  cur_row_d   = s_row;
                  col_start_d = s_col;
                  col_end_d   = e_col;
                  row_end_d   = e_row;
                  row_base_d  = base;
               end
            end
         end
         ST_WRITE: begin
            if (col_last && row_last) begin
               state_d = ST_FINISH;
               done_d  = 1'b1;
            end else if (col_last) begin
               en_d       = 1'b1;
               cur_col_d  = col_start_q;
               cur_row_d  = cur_row_q + 6'd1;
               row_base_d = row_base_q + COLS_A;
               addr_d     = row_base_q + COLS_A + ADDR_WIDTH'(col_start_q);
            end else begin
               en_d      = 1'b1;
               cur_col_d = cur_col_q + 7'd1;
               addr_d    = row_base_q + ADDR_WIDTH'(cur_col_q + 7'd1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      ready_d = (state_d != ST_WRITE);
   end

   // State and output registers; reset aborts any command in flight.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state_q            <= ST_IDLE;
         cur_col_q          <= '0;
         cur_row_q          <= '0;
         col_start_q        <= '0;
         col_end_q          <= '0;
         row_end_q          <= '0;
         row_base_q         <= '0;
         buf_write_addr_out <= '0;
         buf_write_data_out <= '0;
         buf_write_en_out   <= 1'b0;
         done_out           <= 1'b0;
         err_out            <= 1'b0;
         cmd_ready_out      <= 1'b1;
      end else begin
         state_q            <= state_d;
         cur_col_q          <= cur_col_d;
         cur_row_q          <= cur_row_d;
         col_start_q        <= col_start_d;
         col_end_q          <= col_end_d;
         row_end_q          <= row_end_d;
         row_base_q         <= row_base_d;
         buf_write_addr_out <= addr_d;
         buf_write_data_out <= data_d;
         buf_write_en_out   <= en_d;
         done_out           <= done_d;
         err_out            <= err_d;
         cmd_ready_out      <= ready_d;
      end
   end

endmodule

// File: doc/config_tile_writer.md
Name: config_tile_writer

Overview:
- Write-side engine for the 40x23 tile-index screen buffer that the config video renderer scans.
- Accepts drawing commands over a valid/ready handshake: single tile, horizontal run, rectangle fill, full clear.
- Emits one buffer write per cycle on the buffer's write port, with address = row*COLS + col.
- Sits between menu/config control logic and the screen buffer BRAM's second port.

Parameters:
COLS, 40, tiles per screen row
ROWS, 23, tile rows per screen
ADDR_WIDTH, 10, buffer address width (COLS*ROWS must be <= 2**ADDR_WIDTH)

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous reset, active-low (0 = reset)
cmd_valid_in  input  1  command present
cmd_ready_out  output  1  engine can accept a command
cmd_in  input  2  0=PUT, 1=HRUN, 2=RECT, 3=CLEAR
col_in  input  6  start column
row_in  input  5  start row
width_in  input  6  run/rect width in tiles (HRUN, RECT)
height_in  input  5  rect height in tiles (RECT only)
tile_in  input  8  tile index to write
buf_write_addr_out  output  ADDR_WIDTH  buffer write address
buf_write_data_out  output  8  buffer write data
buf_write_en_out  output  1  buffer write strobe
done_out  output  1  one-cycle pulse at command completion
err_out  output  1  one-cycle pulse with done_out when the command was rejected

Behaviour:
- Reset (rst_in=0 at clock edge): state IDLE; cmd_ready_out=1; buf_write_en_out=0; buf_write_addr_out=0; buf_write_data_out=0; done_out=0; err_out=0. Reset mid-command aborts it: no further writes, no done_out.
- All outputs registered. cmd_ready_out=1 only in IDLE.
- Accept: cmd_valid_in && cmd_ready_out at edge N latches all command fields. Inputs ignored while busy.
- States: IDLE -> WRITE (at least one write) or IDLE -> FINISH (zero writes); WRITE -> FINISH after the last write; FINISH -> IDLE.
- In the cycle after accept (N+1), the first write is presented with buf_write_en_out=1. Writes continue one per cycle, back-to-back, with no gaps.
- FINISH cycle: done_out=1, buf_write_en_out=0, cmd_ready_out=1. The engine is IDLE and accepts a new command in that same cycle.
- Write region, with c0=col_in and r0=row_in:
  - PUT: the single tile (c0,r0).
  - HRUN: columns c0..min(c0+width,COLS)-1 on row r0.
  - RECT: the same column span on rows r0..min(r0+height,ROWS)-1, row-major (left to right, then next row).
  - CLEAR: addresses 0..COLS*ROWS-1 ascending; coordinate inputs ignored.
- Clip sums use 7-bit columns and 6-bit rows, so there is no overflow. Columns past COLS are clipped silently. HRUN and RECT never wrap to the next row.
- Rejection (PUT/HRUN/RECT with c0>=COLS or r0>=ROWS): no writes; FINISH at N+1 with done_out=1 and err_out=1.
- Zero width (HRUN/RECT) or zero height (RECT): no writes; FINISH at N+1 with done_out=1 and err_out=0.
- Address generation must not use a multiplier in the write loop. Row base starts at r0*COLS (computed at accept, e.g. shift-add as 32r+8r) and advances by COLS per row. The column adds to the row base.
- Write count per command is cols_span*rows_span. Duration from accept to done_out is count+1 cycles (1 if count is 0).
- buf_write_data_out holds the latched tile for the whole command. buf_write_addr_out and buf_write_data_out are don't-care when the enable is low, but must hold their last values.

Test Plan:
- Reset, then PUT col=5 row=2 tile=0x41 -> single write addr=85 data=0x41 at N+1; done_out=1, err_out=0 at N+2; cmd_ready_out low only during N+1.
- HRUN col=38 row=0 width=5 tile=0x07 -> writes addr 38, 39 at N+1, N+2; done_out at N+3; no write to 40.
- RECT col=1 row=1 width=2 height=2 tile=0x03 -> addrs 41, 42, 81, 82 on consecutive cycles; done_out at N+5. Then issue a PUT held valid -> it is accepted in the done cycle.
- CLEAR tile=0x00 -> 920 consecutive writes, addr 0..919; done_out exactly at N+921; no address 920 ever driven.
- PUT col=40 row=0, then RECT row=23 -> zero writes each; done_out and err_out pulse together at N+1. RECT width=0 -> done_out with err_out=0.
- Start CLEAR, drive rst_in=0 during the 100th write -> buf_write_en_out=0 from the next edge, no done_out. After release, cmd_ready_out=1 and a new PUT executes normally.
